// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes for the Ryuki pipeline trackers.
// Time fields are 32 bits wide; narrower counters are stored zero-extended.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] ex_data;
    logic [31:0] wb_data;
    logic [31:0] time_start;
    logic [31:0] time_end;
    logic        pass_through;
  } trace_output;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_DECODE = 2'd1,
    DECODING    = 2'd2,
    DONE        = 2'd3
  } tracker_state_e;

endpackage

// File: rtl/id_tracker_pipelined_fifo.sv
// Parametrised trace_output FIFO with combinational head and entry count.
// Push while full and pop while empty are ignored.
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  trace_output              push_data,
  input  logic                     pop,
  output trace_output              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  trace_output      mem_q [DEPTH];
  trace_output      mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/id_tracker_pipelined.sv
// ID-stage trace tracker: buffers IF elements, timestamps each decode window,
// marks jump pass-through and hands finished elements to the EX tracker.
module id_tracker_pipelined
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int DEDUP      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TIME_WIDTH-1:0]   counter,
  input  logic                    if_valid,
  output logic                    if_ready,
  input  trace_output             if_data,
  input  logic                    is_decoding,
  input  logic                    jump_done,
  output logic                    id_valid,
  input  logic                    id_ready,
  output trace_output             id_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    stall_seen
);

  localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_WIDTH) - 64'd1);
  localparam logic [31:0] DATA_MASK = 32'((64'd1 << DATA_WIDTH) - 64'd1);

  function automatic trace_output fit_widths(input trace_output t);
    trace_output f;
    f         = t;
    f.pc      = t.pc & ADDR_MASK;
    f.ex_data = t.ex_data & DATA_MASK;
    f.wb_data = t.wb_data & DATA_MASK;
    return f;
  endfunction

  function automatic logic [31:0] to_ts(input logic [TIME_WIDTH-1:0] c);
    return 32'(c);
  endfunction

  function automatic trace_output apply_jump(input trace_output t, input logic jmp);
    trace_output f;
    f = t;
    if (jmp) begin
      f.pass_through = 1'b1;
      f.ex_data      = '0;
      f.wb_data      = '0;
    end
    return f;
  endfunction

  tracker_state_e state_q, state_d;
  trace_output    work_q, work_d;
  trace_output    id_data_q, id_data_d;
  logic           id_valid_q, id_valid_d;
  logic [31:0]    last_instr_q, last_instr_d;
  logic           stall_seen_q, stall_seen_d;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  trace_output    fifo_head;
  logic           accept;
  logic           dup;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fit_widths(if_data)),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  // Duplicates still complete the handshake; they are just not stored.
  assign if_ready  = !fifo_full;
  assign accept    = if_valid && !fifo_full;
  assign dup       = (DEDUP != 0) && (if_data.instruction == last_instr_q);
  assign fifo_push = accept && !dup;

  assign id_valid   = id_valid_q;
  assign id_data    = id_data_q;
  assign stall_seen = stall_seen_q;

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    id_data_d    = id_data_q;
    id_valid_d   = id_valid_q;
    fifo_pop     = 1'b0;
    last_instr_d = accept ? if_data.instruction : last_instr_q;
    stall_seen_d = stall_seen_q || (if_valid && fifo_full);

    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = fifo_head;
          state_d  = WAIT_DECODE;
        end
      end
      WAIT_DECODE: begin
        if (is_decoding) begin
          work_d            = apply_jump(work_q, jump_done);
          work_d.time_start = to_ts(counter);
          state_d           = DECODING;
        end
      end
      DECODING: begin
        work_d = apply_jump(work_q, jump_done);
        if (!is_decoding) begin
          work_d.time_end = to_ts(counter);
          state_d         = DONE;
        end
      end
      DONE: begin
        // Output register is free if empty or being drained this cycle.
        if (!id_valid_q || id_ready) begin
          id_data_d  = work_q;
          id_valid_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            work_d   = fifo_head;
            state_d  = WAIT_DECODE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      id_valid_q   <= 1'b0;
      id_data_q    <= '0;
      last_instr_q <= '0;
      stall_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_valid_q   <= id_valid_d;
      id_data_q    <= id_data_d;
      last_instr_q <= last_instr_d;
      stall_seen_q <= stall_seen_d;
    end
  end

  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

endmodule

// File: tb/tb_id_tracker_pipelined.sv
// Scoreboard bench for id_tracker_pipelined: instance a (DEDUP=1, 32-bit time)
// and instance b (DEDUP=0, 8-bit time) share stimulus and have separate queues.
module tb_id_tracker_pipelined;
  import ryuki_datatypes::*;

  logic        clk;
  logic        rst;
  logic [31:0] counter;
  logic [7:0]  cnt_b;
  logic        if_valid;
  trace_output if_data;
  logic        is_decoding;
  logic        jump_done;
  logic        id_ready;

  logic        if_ready_a, if_ready_b;
  logic        id_valid_a, id_valid_b;
  trace_output id_data_a, id_data_b;
  logic [2:0]  occ_a, occ_b;
  logic        stall_a, stall_b;

  int checks   = 0;
  int failures = 0;

  trace_output q_a[$];
  trace_output q_b[$];
  trace_output s_in[6];

  assign cnt_b = counter[7:0];

  id_tracker_pipelined #(.DEDUP(1)) dut_a (
    .clk(clk), .rst(rst), .counter(counter), .if_valid(if_valid), .if_ready(if_ready_a),
    .if_data(if_data), .is_decoding(is_decoding), .jump_done(jump_done),
    .id_valid(id_valid_a), .id_ready(id_ready), .id_data(id_data_a),
    .occupancy(occ_a), .stall_seen(stall_a)
  );

  id_tracker_pipelined #(.DEDUP(0), .TIME_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .counter(cnt_b), .if_valid(if_valid), .if_ready(if_ready_b),
    .if_data(if_data), .is_decoding(is_decoding), .jump_done(jump_done),
    .id_valid(id_valid_b), .id_ready(id_ready), .id_data(id_data_b),
    .occupancy(occ_b), .stall_seen(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic trace_output mk_in(input logic [31:0] pc, input logic [31:0] ins,
                                        input logic [31:0] ex, input logic [31:0] wb);
    trace_output t;
    t = '0;
    t.pc = pc; t.instruction = ins; t.ex_data = ex; t.wb_data = wb;
    return t;
  endfunction

  function automatic trace_output mk_exp(input trace_output i, input logic [31:0] ts,
                                         input logic [31:0] te, input logic jmp);
    trace_output t;
    t = i;
    t.time_start = ts; t.time_end = te; t.pass_through = jmp;
    if (jmp) begin
      t.ex_data = '0; t.wb_data = '0;
    end
    return t;
  endfunction

  task automatic exp_a(input trace_output i, input logic [31:0] ts, input logic [31:0] te,
                       input logic jmp);
    q_a.push_back(mk_exp(i, ts, te, jmp));
  endtask

  task automatic exp_b(input trace_output i, input logic [31:0] ts, input logic [31:0] te,
                       input logic jmp);
    q_b.push_back(mk_exp(i, ts & 32'hFF, te & 32'hFF, jmp));
  endtask

  task automatic exp_both(input trace_output i, input logic [31:0] ts, input logic [31:0] te,
                          input logic jmp);
    exp_a(i, ts, te, jmp);
    exp_b(i, ts, te, jmp);
  endtask

  task automatic check_v(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic check_tr(input string nm, input trace_output act, input trace_output req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got pc=%h ins=%h ex=%h wb=%h ts=%h te=%h pt=%b required pc=%h ins=%h ex=%h wb=%h ts=%h te=%h pt=%b",
               nm, act.pc, act.instruction, act.ex_data, act.wb_data, act.time_start,
               act.time_end, act.pass_through, req.pc, req.instruction, req.ex_data,
               req.wb_data, req.time_start, req.time_end, req.pass_through);
    end
  endtask

  // Monitor: every output handshake is matched against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid_a && id_ready) begin
        if (q_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_a_unexpected got ins=%h required no output", id_data_a.instruction);
        end else begin
          check_tr("out_a", id_data_a, q_a.pop_front());
        end
      end
      if (id_valid_b && id_ready) begin
        if (q_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_b_unexpected got ins=%h required no output", id_data_b.instruction);
        end else begin
          check_tr("out_b", id_data_b, q_b.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    counter = counter + 1;
  endtask

  task automatic idle(input int n);
    is_decoding = 1'b0;
    jump_done   = 1'b0;
    repeat (n) step();
  endtask

  task automatic push(input trace_output e);
    if_valid = 1'b1;
    if_data  = e;
    step();
    if_valid = 1'b0;
  endtask

  // Decode high for n edges starting at counter=start, then low for the end edge.
  task automatic window(input logic [31:0] start, input int n, input int jidx);
    counter = start;
    for (int k = 0; k < n; k++) begin
      is_decoding = 1'b1;
      jump_done   = (k == jidx);
      step();
    end
    is_decoding = 1'b0;
    jump_done   = 1'b0;
    step();
    idle(3);
  endtask

  trace_output e1, e2, ef, ex, eg, eh;
  trace_output ea[5];

  initial begin
    rst = 1'b1; counter = 0; if_valid = 1'b0; if_data = '0;
    is_decoding = 1'b0; jump_done = 1'b0; id_ready = 1'b1;
    e1 = mk_in(32'h1000, 32'h00A00093, 32'h11, 32'h22);
    e2 = mk_in(32'h1004, 32'h0000006F, 32'h33, 32'h44);
    ef = mk_in(32'h3000, 32'h00500293, 32'h55, 32'h66);
    ex = mk_in(32'h3004, 32'h00600313, 32'h77, 32'h88);
    eg = mk_in(32'h5000, 32'h00700393, 32'h99, 32'hAA);
    eh = mk_in(32'h6000, 32'h00800413, 32'hBB, 32'hCC);
    for (int i = 0; i < 6; i++)
      s_in[i] = mk_in(32'h2000 + 4 * i, 32'h00100013 + i * 32'h00100000, 32'h100 + i, 32'h200 + i);
    for (int i = 0; i < 5; i++)
      ea[i] = mk_in(32'h4000 + 4 * i, 32'h01000013 + i * 32'h00100000, 32'h300 + i, 32'h400 + i);

    repeat (3) step();
    rst = 1'b0;
    check_v("rst_id_valid", {id_valid_a, id_valid_b}, 2'b00);
    check_v("rst_if_ready", {if_ready_a, if_ready_b}, 2'b11);
    check_v("rst_occupancy", {occ_a, occ_b}, 6'd0);
    check_v("rst_stall_seen", {stall_a, stall_b}, 2'b00);
    check_v("rst_id_data_zero", {63'd0, id_data_a == '0}, 64'd1);

    // Plain decode window 10..13
    push(e1); idle(3);
    exp_both(e1, 10, 13, 1'b0);
    window(10, 3, -1);

    // Jump resolved at counter=11
    push(e2); idle(3);
    exp_both(e2, 10, 13, 1'b1);
    window(10, 3, 1);

    // Back-pressure: EX stalled while five elements arrive
    id_ready = 1'b0;
    begin
      int i;
      int guard;
      logic rdy;
      i = 0; guard = 0;
      if_valid = 1'b1;
      while (i < 5 && guard < 20) begin
        if_data = s_in[i];
        rdy = if_ready_a;
        step();
        if (rdy) i++;
        guard++;
      end
      check_v("stall_all_accepted", i, 5);
      if_data = s_in[5];
      step(); step();
      if_valid = 1'b0;
    end
    check_v("stall_occupancy", {occ_a, occ_b}, {3'd4, 3'd4});
    check_v("stall_if_ready", {if_ready_a, if_ready_b}, 2'b00);
    check_v("stall_seen", {stall_a, stall_b}, 2'b11);
    exp_both(s_in[0], 20, 22, 1'b0);
    window(20, 2, -1);
    exp_both(s_in[1], 30, 32, 1'b0);
    window(30, 2, -1);
    check_v("stall_hold_valid", id_valid_a, 1);
    check_v("stall_hold_data", id_data_a.instruction, s_in[0].instruction);
    id_ready = 1'b1;
    idle(3);
    for (int k = 2; k < 5; k++) begin
      exp_both(s_in[k], 32'd20 + 10 * k, 32'd22 + 10 * k, 1'b0);
      window(32'd20 + 10 * k, 2, -1);
    end

    // Duplicate instruction back-to-back behind a parked element
    push(ef); idle(3);
    push(ex); push(ex);
    check_v("dedup_occ_a", occ_a, 1);
    check_v("dedup_occ_b", occ_b, 2);
    exp_both(ef, 70, 72, 1'b0);
    window(70, 2, -1);
    exp_both(ex, 80, 82, 1'b0);
    window(80, 2, -1);
    exp_b(ex, 90, 92, 1'b0);
    window(90, 2, -1);

    // Asynchronous reset in DECODING with three entries queued
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(ea[k]);
    window(100, 2, -1);
    check_v("pre_rst_occ", occ_a, 3);
    check_v("pre_rst_valid", id_valid_a, 1);
    counter = 110;
    is_decoding = 1'b1;
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    check_v("async_rst_id_valid", {id_valid_a, id_valid_b}, 2'b00);
    check_v("async_rst_occ", {occ_a, occ_b}, 6'd0);
    check_v("async_rst_if_ready", {if_ready_a, if_ready_b}, 2'b11);
    check_v("async_rst_stall", {stall_a, stall_b}, 2'b00);
    is_decoding = 1'b0;
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    idle(2);
    push(eg); idle(3);
    exp_both(eg, 120, 122, 1'b0);
    window(120, 2, -1);

    // Counter wrap: 254..257 high, end at 258 (8-bit instance sees 2)
    push(eh); idle(3);
    exp_both(eh, 254, 258, 1'b0);
    window(254, 4, -1);

    begin
      int guard;
      guard = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && guard < 50) begin
        step();
        guard++;
      end
    end
    check_v("drain_q_a", q_a.size(), 0);
    check_v("drain_q_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_tracker_pipelined.md
Name: id_tracker_pipelined

Overview:
- Next-generation ID-stage trace tracker. Receives trace elements from the IF tracker through a parametrised FIFO and timestamps the decode window of each element (start and end) using the global counter.
- Applies jump pass-through marking, then hands completed elements to the EX tracker over a valid/ready handshake.
- Has a separate output register, so decode of instruction N+1 can be tracked while N waits for the EX tracker.

Parameters:
ADDR_WIDTH, 32, address width carried inside trace_output
DATA_WIDTH, 32, data width carried inside trace_output
TIME_WIDTH, 32, width of counter and timestamps
DEPTH, 4, input FIFO entries; power of two, >=2
DEDUP, 1, 1 = discard input whose instruction equals the last accepted instruction

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
counter  in  TIME_WIDTH  global cycle counter
if_valid  in  1  IF tracker offers if_data
if_ready  out  1  FIFO can accept
if_data  in  trace_output  element from IF tracker
is_decoding  in  1  ID stage busy decoding
jump_done  in  1  ID stage resolved a jump
id_valid  out  1  id_data valid for EX tracker
id_ready  in  1  EX tracker accepts
id_data  out  trace_output  completed element
occupancy  out  $clog2(DEPTH)+1  FIFO entry count
stall_seen  out  1  sticky: if_valid seen while !if_ready

Behaviour:
- Reset (async, any state, mid-transaction included):
  - FIFO pointers and occupancy go to 0; FSM goes to IDLE.
  - id_valid, stall_seen and last-instruction register go to 0; id_data goes to all-zero.
  - if_ready goes to 1. Any in-flight element is lost.
- Input handshake:
  - Push on if_valid && if_ready. if_ready = !full, with no same-cycle pop bypass.
  - With DEDUP=1, an input whose instruction equals the last accepted instruction is handshaken but not stored.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the working register and go to WAIT_DECODE. Pop latency is 1 cycle.
  - WAIT_DECODE: on the first cycle is_decoding=1, set time_start=counter, apply the jump check, and go to DECODING. If is_decoding is already high on the entry cycle, latch on that cycle.
  - DECODING: apply the jump check every cycle. On the first cycle is_decoding=0, set time_end=counter and go to DONE.
  - DONE:
    - If the output register is free (!id_valid, or id_valid&&id_ready this cycle), load it and set id_valid=1.
    - Then go to WAIT_DECODE with the next FIFO head if the FIFO is non-empty, else to IDLE.
    - Otherwise stay in DONE; decode edges arriving meanwhile are not tracked.
- Jump check: when jump_done=1, set pass_through=1 and zero ex_data and wb_data. The flag is never cleared for that element.
- Output: id_valid stays high and id_data stays stable until id_ready. Clear id_valid on handshake unless it is reloaded in the same cycle.
- Counter wrap: timestamps are raw counter values with no correction. time_end<time_start after wrap is legal.
- occupancy: +1 on push, -1 on pop; unchanged on simultaneous push and pop.

Decomposition:
- ryuki_datatypes holds the trace_output typedef (existing) and the new tracker-state enum typedef (IDLE/WAIT_DECODE/DECODING/DONE, 2 bits).
- Sub-module trace_fifo: parametrised trace_output FIFO (DEPTH, push/pop, full/empty, count).

Test Plan:
1. Single element, instruction 0x00A00093, is_decoding high at counter=10..12 and low at counter=13, id_ready=1 -> id_data time_start=10, time_end=13, pass_through=0, id_valid pulses 1 cycle.
2. jump_done=1 at counter=11 during decode -> pass_through=1, ex_data=0, wb_data=0.
3. id_ready=0 while 5 elements are pushed with DEPTH=4 -> if_ready drops after 4 (5th only if one has popped into the working register), stall_seen=1, no element lost, and all appear in order once id_ready=1.
4. DEDUP=1, same instruction pushed twice back-to-back -> occupancy=1 and one output; with DEDUP=0 -> two outputs.
5. rst asserted during DECODING with occupancy=3 -> same cycle: id_valid=0, occupancy=0, if_ready=1; next decode tracked from IDLE.
6. TIME_WIDTH=8, decode from counter=254 to counter=2 -> time_start=254, time_end=2.
